// File: rtl/conv2d_mc_pkg.sv
// Shared constants and helpers for the multi-channel conv2d engine.
package conv2d_mc_pkg;

  // Engine control states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Number of weight words across all output channels.
  function automatic int unsigned wcnt(input int unsigned out_ch, input int unsigned in_ch,
                                       input int unsigned k);
    return out_ch * in_ch * k * k;
  endfunction

  // Config address width: weights followed by one bias per output channel.
  function automatic int unsigned cfg_addr_w(input int unsigned out_ch, input int unsigned in_ch,
                                             input int unsigned k);
    return $clog2(wcnt(out_ch, in_ch, k) + out_ch + 1);
  endfunction

  // Output-channel index width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned out_ch);
    return (out_ch > 1) ? $clog2(out_ch) : 1;
  endfunction

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv2d_mc_engine_if.sv
// Window, result and config buses of the conv2d engine.
interface conv2d_mc_engine_if
  import conv2d_mc_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned IN_CH   = 4,
  parameter int unsigned OUT_CH  = 8,
  parameter int unsigned K       = 3,
  parameter int unsigned SHIFT_W = 5
) ();
  localparam int unsigned AW   = cfg_addr_w(OUT_CH, IN_CH, K);
  localparam int unsigned CH_W = ch_w(OUT_CH);

  logic [DATA_W*IN_CH-1:0] window [K][K];
  logic                    win_valid;
  logic                    win_ready;
  logic                    cfg_relu_en;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic signed [OUT_W-1:0] out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_last;
  logic                    out_sat;
  logic                    out_valid;
  logic                    out_ready;
  logic                    cfg_write;
  logic [AW-1:0]           cfg_addr;
  logic signed [DATA_W-1:0] cfg_wdata;
  logic                    cfg_drop;

  modport master (
    output window, win_valid, cfg_relu_en, cfg_shift, out_ready, cfg_write, cfg_addr, cfg_wdata,
    input  win_ready, out_data, out_ch, out_last, out_sat, out_valid, cfg_drop
  );

  modport slave (
    input  window, win_valid, cfg_relu_en, cfg_shift, out_ready, cfg_write, cfg_addr, cfg_wdata,
    output win_ready, out_data, out_ch, out_last, out_sat, out_valid, cfg_drop
  );
endinterface

// File: rtl/conv2d_requant.sv
// Combinational requantiser: optional ReLU, rounding right shift, saturation.
module conv2d_requant
  import conv2d_mc_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu_en,
  input  logic [SHIFT_W-1:0]      shift,
  output logic signed [OUT_W-1:0] res_c,
  output logic                    sat_c
);
  // One guard bit so the rounding increment cannot overflow.
  localparam int unsigned EW = ACC_W + 1;

  logic signed [ACC_W-1:0] relu_v;
  logic signed [EW-1:0]    ext;
  logic signed [EW-1:0]    rnd;
  logic signed [63:0]      wide;
  logic signed [63:0]      clip;

  // ReLU, round-half-up shift, then clamp to the output range.
  always_comb begin
    relu_v = (relu_en && acc[ACC_W-1]) ? '0 : acc;
    ext    = EW'(relu_v);
    rnd    = ext;
    if (shift != '0) begin
      rnd = (ext + (EW'(1) <<< (shift - SHIFT_W'(1)))) >>> shift;
    end
    wide  = 64'(rnd);
    clip  = sat_s(wide, OUT_W);
    res_c = OUT_W'(clip);
    sat_c = (clip != wide);
  end
endmodule

// File: rtl/conv2d_mc_engine.sv
// Multi-channel conv2d engine: one K x K x IN_CH window in, OUT_CH results out.
module conv2d_mc_engine
  import conv2d_mc_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned IN_CH   = 4,
  parameter int unsigned OUT_CH  = 8,
  parameter int unsigned K       = 3,
  parameter int unsigned SHIFT_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  conv2d_mc_engine_if.slave bus
);
  localparam int unsigned WCNT = wcnt(OUT_CH, IN_CH, K);
  localparam int unsigned AW   = cfg_addr_w(OUT_CH, IN_CH, K);
  localparam int unsigned CH_W = ch_w(OUT_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(OUT_CH - 1);

  logic [1:0]              state;
  logic [1:0]              state_d;
  logic [CH_W-1:0]         oc;
  logic [CH_W-1:0]         mac_oc;
  logic                    beat_c;
  logic                    cfg_ok_c;
  logic [DATA_W*IN_CH-1:0] win_q [K][K];
  logic                    relu_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic signed [DATA_W-1:0] wgt  [OUT_CH][IN_CH][K][K];
  logic signed [DATA_W-1:0] bias [OUT_CH];
  logic signed [DATA_W-1:0] wsel [IN_CH][K][K];
  logic signed [DATA_W-1:0] bsel;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [OUT_W-1:0] res_c;
  logic                    sat_c;

  // Next state and the channel the MAC works on this cycle.
  always_comb begin
    state_d  = state;
    beat_c   = (state == ST_OUT) && bus.out_ready && (oc != LAST_CH);
    mac_oc   = (state == ST_OUT && oc != LAST_CH) ? oc + CH_W'(1) : oc;
    cfg_ok_c = (state == ST_IDLE) && (bus.cfg_addr < AW'(WCNT + OUT_CH));
    case (state)
      ST_IDLE: if (bus.win_valid) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_OUT;
      ST_OUT:  if (bus.out_ready && oc == LAST_CH) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Full-window multiply-accumulate for the selected output channel.
  always_comb begin
    bsel = '0;
    for (int unsigned i = 0; i < IN_CH; i++)
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) wsel[i][r][c] = '0;
    for (int unsigned o = 0; o < OUT_CH; o++) begin
      if (mac_oc == CH_W'(o)) begin
        bsel = bias[o];
        wsel = wgt[o];
      end
    end
    acc_c = ACC_W'(bsel);
    for (int unsigned i = 0; i < IN_CH; i++)
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++)
          acc_c = acc_c + ACC_W'($signed(win_q[r][c][i*DATA_W +: DATA_W])) * ACC_W'(wsel[i][r][c]);
  end

  conv2d_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_requant (
    .acc     (acc_c),
    .relu_en (relu_q),
    .shift   (shift_q),
    .res_c   (res_c),
    .sat_c   (sat_c)
  );

  // Window capture, channel sequencing and registered result beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win_q[r][c] <= '0;
      relu_q        <= 1'b0;
      shift_q       <= '0;
      oc            <= '0;
      bus.win_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.win_ready <= (state_d == ST_IDLE);
      bus.out_valid <= (state_d == ST_OUT);
      if (state == ST_IDLE && bus.win_valid) begin
        win_q   <= bus.window;
        relu_q  <= bus.cfg_relu_en;
        shift_q <= bus.cfg_shift;
        oc      <= '0;
      end
      if (state == ST_LOAD || beat_c) begin
        oc           <= mac_oc;
        bus.out_data <= res_c;
        bus.out_sat  <= sat_c;
        bus.out_ch   <= mac_oc;
        bus.out_last <= (mac_oc == LAST_CH);
      end
    end
  end

  // Weight/bias storage; writes are only honoured while idle and in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < OUT_CH; o++) begin
        bias[o] <= '0;
        for (int unsigned i = 0; i < IN_CH; i++)
          for (int unsigned r = 0; r < K; r++)
            for (int unsigned c = 0; c < K; c++) wgt[o][i][r][c] <= '0;
      end
      bus.cfg_drop <= 1'b0;
    end else begin
      bus.cfg_drop <= bus.cfg_write && !cfg_ok_c;
      if (bus.cfg_write && cfg_ok_c) begin
        for (int unsigned o = 0; o < OUT_CH; o++) begin
          if (bus.cfg_addr == AW'(WCNT + o)) bias[o] <= bus.cfg_wdata;
          for (int unsigned i = 0; i < IN_CH; i++)
            for (int unsigned r = 0; r < K; r++)
              for (int unsigned c = 0; c < K; c++)
                if (bus.cfg_addr == AW'(((o * IN_CH + i) * K + r) * K + c))
                  wgt[o][i][r][c] <= bus.cfg_wdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv2d_mc_engine.sv
// Self-checking bench for conv2d_mc_engine with a reference model of the arithmetic.
module tb_conv2d_mc_engine;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int IN_CH   = 1;
  localparam int OUT_CH  = 2;
  localparam int K       = 3;
  localparam int SHIFT_W = 5;
  localparam int WCNT    = OUT_CH * IN_CH * K * K;
  localparam int AW      = 5;

  typedef struct {
    int data;
    bit sat;
    int ch;
    bit last;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  beat_t exp_q[$];
  int   mflat [WCNT+OUT_CH];
  int   cur_pix [K][K][IN_CH];
  int   img [5][5];

  conv2d_mc_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IN_CH(IN_CH), .OUT_CH(OUT_CH),
                        .K(K), .SHIFT_W(SHIFT_W)) bus ();

  conv2d_mc_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .IN_CH(IN_CH),
                     .OUT_CH(OUT_CH), .K(K), .SHIFT_W(SHIFT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference result for channel oc of the current window.
  function automatic void model(input int oc, input bit relu, input int sh, output int d, output bit s);
    longint a, v, hi, lo;
    int w32;
    a = longint'(mflat[WCNT+oc]);
    for (int ic = 0; ic < IN_CH; ic++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          a += longint'(cur_pix[kr][kc][ic]) * longint'(mflat[((oc*IN_CH+ic)*K+kr)*K+kc]);
    w32 = int'(a);
    v = longint'(w32);
    if (relu && v < 0) v = 0;
    if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    s = (v > hi) || (v < lo);
    d = int'((v > hi) ? hi : ((v < lo) ? lo : v));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int r0, input int c0);
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        for (int ic = 0; ic < IN_CH; ic++) cur_pix[kr][kc][ic] = img[r0+kr][c0+kc];
  endtask

  task automatic fill_win(input int v);
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        for (int ic = 0; ic < IN_CH; ic++) cur_pix[kr][kc][ic] = v;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!(bus.win_ready === 1'b1 && exp_q.size() == 0) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: timeout, win_ready=%0b pending=%0d", bus.win_ready, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (bus.out_valid !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: timeout, out_valid=%0b expected 1", bus.out_valid);
    end
  endtask

  task automatic cfg_wr(input int addr, input int data, input bit ok);
    bus.cfg_write = 1'b1;
    bus.cfg_addr  = AW'(addr);
    bus.cfg_wdata = DATA_W'(data);
    tick();
    bus.cfg_write = 1'b0;
    check("cfg_drop", longint'(bus.cfg_drop), longint'(!ok));
    if (ok) mflat[addr] = data;
  endtask

  // Present one window; queue the beats the model predicts for it.
  task automatic send(input bit relu, input int sh);
    beat_t b;
    int d;
    bit s;
    wait_ready();
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        for (int ic = 0; ic < IN_CH; ic++)
          bus.window[kr][kc][ic*DATA_W +: DATA_W] = DATA_W'(cur_pix[kr][kc][ic]);
    bus.cfg_relu_en = relu;
    bus.cfg_shift   = SHIFT_W'(sh);
    bus.win_valid   = 1'b1;
    for (int oc = 0; oc < OUT_CH; oc++) begin
      model(oc, relu, sh, d, s);
      b.data = d;
      b.sat  = s;
      b.ch   = oc;
      b.last = (oc == OUT_CH - 1);
      exp_q.push_back(b);
    end
    tick();
    bus.win_valid = 1'b0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++) bus.window[kr][kc] = (DATA_W*IN_CH)'($urandom);
    bus.cfg_relu_en = ~relu;
    bus.cfg_shift   = SHIFT_W'($urandom);
  endtask

  // Checks every valid output beat against the head of the expected queue.
  always @(negedge clk) begin : cmp
    beat_t e;
    if (rst_n && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: ch %0d data %0d, expected no beat", bus.out_ch, $signed(bus.out_data));
      end else begin
        e = exp_q[0];
        check("beat_data", longint'($signed(bus.out_data)), longint'(e.data));
        check("beat_ch", longint'(bus.out_ch), longint'(e.ch));
        check("beat_last", longint'(bus.out_last), longint'(e.last));
        check("beat_sat", longint'(bus.out_sat), longint'(e.sat));
        check("win_ready_busy", longint'(bus.win_ready), 0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int d;
    bit s;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img[r][c] = r * 5 + c + 1;
    for (int i = 0; i < WCNT + OUT_CH; i++) mflat[i] = 0;
    bus.win_valid   = 1'b0;
    bus.cfg_relu_en = 1'b0;
    bus.cfg_shift   = '0;
    bus.out_ready   = 1'b0;
    bus.cfg_write   = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_wdata   = '0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++) bus.window[kr][kc] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_ready", longint'(bus.win_ready), 1);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_last", longint'(bus.out_last), 0);
    check("rst_out_sat", longint'(bus.out_sat), 0);
    check("rst_cfg_drop", longint'(bus.cfg_drop), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_ch", longint'(bus.out_ch), 0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: edge kernel on oc0, box kernel plus bias on oc1.
    for (int oc = 0; oc < OUT_CH; oc++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          cfg_wr(((oc*IN_CH)*K+kr)*K+kc, (oc == 0) ? ((kc == 0) ? 1 : ((kc == 2) ? -1 : 0)) : 1, 1'b1);
    cfg_wr(WCNT + 0, 0, 1'b1);
    cfg_wr(WCNT + 1, 5, 1'b1);
    set_win(0, 0);
    model(0, 1'b0, 0, d, s); check("pin_s1_ch0", d, -6);
    model(1, 1'b0, 0, d, s); check("pin_s1_ch1", d, 68); check("pin_s1_ch1_sat", s, 0);
    model(0, 1'b1, 2, d, s); check("pin_s2_ch0", d, 0);
    model(1, 1'b1, 2, d, s); check("pin_s2_ch1", d, 17);
    bus.out_ready = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        set_win(r, c);
        model(0, 1'b0, 0, d, s); check("pin_s1_ch0_all", d, -6);
        send(1'b0, 0);
      end
    wait_ready();

    // Scenario 2: ReLU and rounding shift.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        set_win(r, c);
        send(1'b1, 2);
      end
    wait_ready();

    // Scenario 4: backpressure on the first beat.
    set_win(0, 0);
    bus.out_ready = 1'b0;
    send(1'b0, 0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", longint'(bus.out_valid), 1);
      check("bp_ch", longint'(bus.out_ch), 0);
      check("bp_data", longint'($signed(bus.out_data)), -6);
      check("bp_win_ready", longint'(bus.win_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_second_valid", longint'(bus.out_valid), 1);
    check("bp_second_ch", longint'(bus.out_ch), 1);
    check("bp_second_last", longint'(bus.out_last), 1);
    tick();
    check("bp_done_valid", longint'(bus.out_valid), 0);
    check("bp_done_win_ready", longint'(bus.win_ready), 1);
    wait_ready();

    // Scenario 5: rejected config writes.
    bus.out_ready = 1'b0;
    send(1'b0, 0);
    wait_valid();
    cfg_wr(0, 99, 1'b0);
    tick();
    check("cfg_drop_pulse_end", longint'(bus.cfg_drop), 0);
    bus.out_ready = 1'b1;
    wait_ready();
    cfg_wr(WCNT + OUT_CH, 7, 1'b0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        set_win(r, c);
        send(1'b0, 0);
      end
    wait_ready();

    // Scenario 3: saturation in both directions.
    fill_win(127);
    for (int a = 0; a < WCNT; a++) cfg_wr(a, 127, 1'b1);
    model(0, 1'b0, 0, d, s); check("pin_s3_pos", d, 127); check("pin_s3_pos_sat", s, 1);
    send(1'b0, 0);
    wait_ready();
    for (int a = 0; a < WCNT; a++) cfg_wr(a, -128, 1'b1);
    model(1, 1'b0, 0, d, s); check("pin_s3_neg", d, -128); check("pin_s3_neg_sat", s, 1);
    send(1'b0, 0);
    wait_ready();

    // Scenario 6: reset during an output sequence.
    bus.out_ready = 1'b0;
    set_win(1, 1);
    send(1'b0, 0);
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", longint'(bus.out_valid), 0);
    check("rst_mid_win_ready", longint'(bus.win_ready), 1);
    exp_q.delete();
    for (int i = 0; i < WCNT + OUT_CH; i++) mflat[i] = 0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_no_partial", longint'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    set_win(1, 1);
    model(0, 1'b0, 0, d, s); check("pin_s6_ch0", d, 0);
    model(1, 1'b0, 0, d, s); check("pin_s6_ch1", d, 0);
    send(1'b0, 0);
    wait_ready();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv2d_mc_engine.md
Name: conv2d_mc_engine

Overview:
Multi-channel successor to the single-shot conv2d engine. It accepts one K×K×IN_CH window per handshake and streams OUT_CH results, one output channel per beat. Each result is a full multiply-accumulate over the window plus a per-channel bias, followed by optional ReLU, a rounding right-shift and saturation to OUT_W. Weights and biases load through the existing cfg write port; output beats carry a channel index and a last flag for the downstream feature-map writer.

Parameters:
DATA_W, 8, signed pixel/weight/bias width
ACC_W, 32, accumulator width (two's-complement wrap)
OUT_W, 8, signed output width after requant
IN_CH, 4, input channels per window position
OUT_CH, 8, output channels produced per window
K, 3, kernel size (K×K)
SHIFT_W, 5, width of requant shift control

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
window  in  [DATA_W*IN_CH-1:0] x [K][K]  window; channel ic at bits [ic*DATA_W +: DATA_W], signed
win_valid  in  1  window valid
win_ready  out  1  engine idle, can accept a window
cfg_relu_en  in  1  ReLU enable, sampled on window accept
cfg_shift  in  SHIFT_W  requant right-shift, sampled on window accept
out_data  out  OUT_W  signed requantised result
out_ch  out  $clog2(OUT_CH) (min 1)  output channel of current beat
out_last  out  1  beat is channel OUT_CH-1
out_sat  out  1  result was saturated
out_valid  out  1  output valid
out_ready  in  1  downstream ready
cfg_write  in  1  weight/bias write strobe
cfg_addr  in  $clog2(WCNT+OUT_CH+1)  WCNT=OUT_CH*IN_CH*K*K
cfg_wdata  in  DATA_W  signed write data
cfg_drop  out  1  one-cycle pulse: write rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE; win_ready=1; out_valid/out_last/out_sat/cfg_drop=0; out_data/out_ch=0; all weights and biases=0.
- Weight address = ((oc*IN_CH+ic)*K+kr)*K+kc. Bias[oc] lives at WCNT+oc. Bias is sign-extended to ACC_W.
- cfg_write is applied on the clock edge only in IDLE with an in-range address.
- A cfg_write outside IDLE, or to an address >= WCNT+OUT_CH, does not update storage and pulses cfg_drop the next cycle.
- FSM IDLE/LOAD/OUT:
  - IDLE: win_ready=1. On win_valid&&win_ready, latch window, relu_en and shift; oc=0; go to LOAD.
  - LOAD (1 cycle): compute channel oc; register result; go to OUT.
  - OUT: out_valid=1. On out_ready, if oc==OUT_CH-1 go to IDLE; otherwise oc++ and register the next channel in the same edge (back-to-back beats).
- Latency: accept at edge N; first out_valid after edge N+1. With out_ready held high, channels arrive on consecutive cycles; win_ready returns the cycle after the last handshake.
- Backpressure: while out_valid&&!out_ready, out_data, out_ch, out_last and out_sat stay stable, and win_ready=0.
- Arithmetic:
  - acc = bias[oc] + Σ over ic,kr,kc of pixel×weight, all signed, wrapping modulo 2^ACC_W.
  - If relu_en and acc<0, acc=0.
  - If shift>0, acc = (acc + 2^(shift-1)) >>> shift (arithmetic shift, round half up); shift=0 passes acc through.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when clipping occurred.
- Reset mid-operation aborts the window; no partial beats are issued after release.
- The window is latched, so changes on window after accept have no effect.

Decomposition:
- Package conv2d_mc_pkg holds:
  - state enum (IDLE, LOAD, OUT)
  - WCNT and address-width localparam functions
  - a signed saturate function
- One sub-module, conv2d_requant: combinational ReLU, round, shift and saturate (ACC_W in, OUT_W + sat out). The MAC stays inline.

Test Plan:
1. Config IN_CH=1, OUT_CH=2, K=3. Image 5×5 = 1..25. oc0 kernel rows [1,0,-1], bias 0; oc1 kernel all-ones, bias 5; shift 0, relu off. At centre (1,1) -> beats (ch0, -6, last=0), (ch1, OUT_W=8 sat? no: 68, last=1); all 9 positions give ch0=-6.
2. Same windows, relu_en=1, shift=2 -> ch0=0; ch1 at (1,1) = (68+2)>>2 = 17.
3. All weights 127, pixels 127, shift 0 -> out_data=127, out_sat=1. Weights -128 -> out_data=-128, out_sat=1.
4. Hold out_ready=0 for 3 cycles after the first out_valid -> ch0 beat stable, win_ready=0. After release, ch0 and ch1 complete on consecutive cycles; win_ready=1 on the following cycle.
5. cfg_write during OUT, and cfg_write to address WCNT+OUT_CH -> cfg_drop pulses; a re-run of scenario 1 gives unchanged results.
6. Assert rst_n low during OUT for 1 cycle -> out_valid=0 immediately and win_ready=1. Weights are cleared, so the next window yields ch0=0 and ch1=0.
